// File: rtl/multdiv_stall_ctrl_if.sv
// rtl/multdiv_stall_ctrl_if.sv - D/X, multdiv unit and X/M signals around the multdiv stall controller
interface multdiv_stall_ctrl_if;
  logic [4:0]  op_x;
  logic [4:0]  aluop_x;
  logic [31:0] rega_x;
  logic [31:0] regb_x;
  logic        md_ready;
  logic [31:0] md_result;
  logic        md_exception;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] md_operand_a;
  logic [31:0] md_operand_b;
  logic        stall;
  logic        xm_bubble;
  logic        result_valid;
  logic [31:0] result;
  logic        result_overflow;
  logic        busy;

  // master: the controller; slave: the pipeline and multdiv unit around it
  modport master (
    input  op_x, aluop_x, rega_x, regb_x, md_ready, md_result, md_exception,
    output ctrl_mult, ctrl_div, md_operand_a, md_operand_b, stall, xm_bubble,
           result_valid, result, result_overflow, busy
  );

  modport slave (
    output op_x, aluop_x, rega_x, regb_x, md_ready, md_result, md_exception,
    input  ctrl_mult, ctrl_div, md_operand_a, md_operand_b, stall, xm_bubble,
           result_valid, result, result_overflow, busy
  );
endinterface

// File: rtl/multdiv_stall_ctrl.sv
// rtl/multdiv_stall_ctrl.sv - freezes the front of the pipeline while the shared multdiv unit runs
module multdiv_stall_ctrl #(
  parameter int MAX_WAIT = 40
) (
  input logic             clock,
  input logic             reset,
  multdiv_stall_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [5:0] WAIT_LAST = 6'(MAX_WAIT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  wait_cnt;
  logic        is_mult;
  logic        is_div;
  logic        md_op;
  logic        ctrl_mult_q;
  logic        ctrl_div_q;
  logic [31:0] operand_a_q;
  logic [31:0] operand_b_q;
  logic [31:0] result_q;
  logic        overflow_q;
  logic        timeout;

  assign is_mult = (bus.op_x == 5'b00000) && (bus.aluop_x == 5'b00110);
  assign is_div  = (bus.op_x == 5'b00000) && (bus.aluop_x == 5'b00111);
  assign md_op   = is_mult | is_div;
  assign timeout = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (md_op) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (bus.md_ready || timeout) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The start-pulse flops double as the latched mult/div kind: set on launch, live only in START.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      operand_a_q <= 32'h0;
      operand_b_q <= 32'h0;
      wait_cnt    <= 6'd0;
      result_q    <= 32'h0;
      overflow_q  <= 1'b0;
    end else begin
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (md_op) begin
            operand_a_q <= bus.rega_x;
            operand_b_q <= bus.regb_x;
            ctrl_mult_q <= is_mult;
            ctrl_div_q  <= is_div;
          end
        end
        S_START: wait_cnt <= 6'd0;
        S_WAIT: begin
          if (bus.md_ready) begin
            result_q   <= bus.md_result;
            overflow_q <= bus.md_exception;
          end else if (timeout) begin
            result_q   <= 32'h0;
            overflow_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stall is combinational so the detecting cycle is already frozen; gated so reset forces it low.
  assign bus.stall           = reset & (((state == S_IDLE) & md_op) | (state == S_START) | (state == S_WAIT));
  assign bus.xm_bubble       = bus.stall;
  assign bus.busy            = (state != S_IDLE);
  assign bus.result_valid    = (state == S_DONE);
  assign bus.ctrl_mult       = ctrl_mult_q;
  assign bus.ctrl_div        = ctrl_div_q;
  assign bus.md_operand_a    = operand_a_q;
  assign bus.md_operand_b    = operand_b_q;
  assign bus.result          = result_q;
  assign bus.result_overflow = overflow_q;

endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// tb/tb_multdiv_stall_ctrl.sv - scoreboard bench with a D/X register model and a latency-programmable multdiv unit
module tb_multdiv_stall_ctrl;
  localparam int MAX_WAIT = 40;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  multdiv_stall_ctrl_if bus();
  multdiv_stall_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    bit          early;
  } instr_t;

  typedef struct {
    bit          is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } exp_t;

  instr_t      prog[$];
  exp_t        sb[$];
  instr_t      cur;
  instr_t      nop;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          idx = 0;
  bit          mon_en = 0;
  bit          active = 0;
  bit          finished = 0;
  logic        stall_s = 1'b0;
  logic        prev_pulse = 1'b0;
  int          u_start = 0;
  int          u_lat = 0;
  logic [31:0] u_res = 32'h0;
  logic        u_exc = 1'b0;
  int          mon_start = 0;
  logic [31:0] held_res = 32'h0;
  logic        held_ovf = 1'b0;

  function automatic bit is_md(instr_t i);
    return (i.op == 5'd0) && (i.aluop == 5'd6 || i.aluop == 5'd7);
  endfunction

  // Behaviour of the multdiv unit itself: {exception, result}.
  function automatic logic [32:0] md_calc(input bit dv, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (dv) begin
      if (b == 32'h0) return {1'b1, 32'h0};
      return {1'b0, a / b};
    end
    p = {32'h0, a} * {32'h0, b};
    return {(p[63:32] != 32'h0), p[31:0]};
  endfunction

  function automatic instr_t mk(input logic [4:0] op, input logic [4:0] aluop, input logic [31:0] a,
                                input logic [31:0] b, input int lat, input bit early);
    instr_t i;
    i.op = op; i.aluop = aluop; i.a = a; i.b = b; i.lat = lat; i.early = early;
    return i;
  endfunction

  // Unit ready within the WAIT window gives its answer; otherwise the watchdog gives 0 with overflow.
  function automatic exp_t mk_exp(instr_t i);
    exp_t        e;
    logic [32:0] r;
    e.is_div = (i.aluop == 5'd7);
    e.a = i.a;
    e.b = i.b;
    r = md_calc(e.is_div, i.a, i.b);
    if (i.lat <= MAX_WAIT) begin
      e.res = r[31:0]; e.ovf = r[32]; e.lat = i.lat;
    end else begin
      e.res = 32'h0; e.ovf = 1'b1; e.lat = MAX_WAIT;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic apply(instr_t i);
    bus.op_x = i.op; bus.aluop_x = i.aluop; bus.rega_x = i.a; bus.regb_x = i.b;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl_mult"}, 64'(bus.ctrl_mult), 64'h0);
    check({tag, "_ctrl_div"}, 64'(bus.ctrl_div), 64'h0);
    check({tag, "_operand_a"}, 64'(bus.md_operand_a), 64'h0);
    check({tag, "_operand_b"}, 64'(bus.md_operand_b), 64'h0);
    check({tag, "_stall"}, 64'(bus.stall), 64'h0);
    check({tag, "_xm_bubble"}, 64'(bus.xm_bubble), 64'h0);
    check({tag, "_result_valid"}, 64'(bus.result_valid), 64'h0);
    check({tag, "_result"}, 64'(bus.result), 64'h0);
    check({tag, "_overflow"}, 64'(bus.result_overflow), 64'h0);
    check({tag, "_busy"}, 64'(bus.busy), 64'h0);
  endtask

  // Monitor plus the multdiv unit's start detection, both on the falling edge.
  always @(negedge clock) begin
    logic pulse;
    exp_t e;
    logic [32:0] r;
    stall_s = bus.stall;
    if (mon_en) begin
      pulse = bus.ctrl_mult | bus.ctrl_div;
      if (pulse) begin
        check("pulse_onehot", 64'(bus.ctrl_mult & bus.ctrl_div), 64'h0);
        check("pulse_width", 64'(prev_pulse), 64'h0);
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pulse_unexpected: start pulse with empty scoreboard (cycle %0d)", cyc);
        end else begin
          check("pulse_kind_div", 64'(bus.ctrl_div), 64'(sb[0].is_div));
          check("operand_a", 64'(bus.md_operand_a), 64'(sb[0].a));
          check("operand_b", 64'(bus.md_operand_b), 64'(sb[0].b));
        end
        mon_start = cyc;
      end
      prev_pulse = pulse;

      if (bus.result_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL result_unexpected: result_valid with empty scoreboard (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("result", 64'(bus.result), 64'(e.res));
          check("result_overflow", 64'(bus.result_overflow), 64'(e.ovf));
          check("done_cycle", 64'(cyc), 64'(mon_start + e.lat + 1));
          check("stall_at_done", 64'(bus.stall), 64'h0);
          held_res = e.res;
          held_ovf = e.ovf;
        end
        active = 0;
      end else begin
        check("result_hold", 64'(bus.result), 64'(held_res));
        check("overflow_hold", 64'(bus.result_overflow), 64'(held_ovf));
      end
      check("bubble_eq_stall", 64'(bus.xm_bubble), 64'(bus.stall));
      if (!bus.busy) check("idle_stall", 64'(bus.stall), 64'(is_md(cur)));

      if (pulse) begin
        active  = 1;
        u_start = cyc;
        u_lat   = cur.lat;
        r       = md_calc(bus.ctrl_div, bus.md_operand_a, bus.md_operand_b);
        u_exc   = r[32];
        u_res   = r[31:0];
      end
    end
  end

  initial begin
    nop = mk(5'd0, 5'd0, 32'h0, 32'h0, 0, 0);
    cur = nop;
    apply(mk(5'd0, 5'd6, 32'h1234, 32'h5678, 1, 0));
    bus.md_ready = 1'b0; bus.md_result = 32'h0; bus.md_exception = 1'b0;

    prog.push_back(mk(5'd0, 5'd6, 32'd7, 32'd6, 4, 0));
    prog.push_back(mk(5'd0, 5'd7, 32'd100, 32'd7, 1, 0));
    prog.push_back(mk(5'd0, 5'd6, 32'd9, 32'd9, 1, 1));
    prog.push_back(mk(5'd0, 5'd7, 32'd1000, 32'd3, 1000, 0));
    prog.push_back(mk(5'd0, 5'd6, 32'd12, 32'd12, 1, 0));
    prog.push_back(mk(5'd0, 5'd7, 32'd50, 32'd5, 1, 0));
    prog.push_back(mk(5'd0, 5'd0, 32'd3, 32'd4, 0, 0));
    prog.push_back(mk(5'd5, 5'd6, 32'd3, 32'd4, 0, 0));
    prog.push_back(mk(5'd0, 5'd5, 32'd3, 32'd4, 0, 0));
    prog.push_back(mk(5'd0, 5'd7, 32'd77, 32'd0, 3, 0));
    prog.push_back(mk(5'd0, 5'd6, 32'hFFFF_FFFF, 32'd2, MAX_WAIT, 0));
    prog.push_back(mk(5'd0, 5'd6, 32'd5, 32'd5, MAX_WAIT + 1, 0));
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0)
          prog.push_back(mk(5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)), $urandom, $urandom, 0, 0));
        else
          prog.push_back(mk(5'd0, 5'($urandom_range(0, 5)), $urandom, $urandom, 0, 0));
      end else begin
        logic [31:0] b;
        int          lat;
        b = ($urandom_range(0, 7) == 0) ? 32'h0 :
            ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 100)) : $urandom;
        case ($urandom_range(0, 9))
          0:       lat = MAX_WAIT;
          1:       lat = MAX_WAIT + 1;
          default: lat = $urandom_range(1, 8);
        endcase
        prog.push_back(mk(5'd0, 5'($urandom_range(6, 7)), $urandom, b, lat, ($urandom_range(0, 3) == 0)));
      end
    end

    // Reset state, with a md opcode present to show stall is held low under reset.
    repeat (3) @(posedge clock);
    #1 check_all_zero("reset");
    apply(nop);
    @(negedge clock);
    reset = 1'b1;
    mon_en = 1;

    for (int t = 0; t < 20000 && !finished; t++) begin
      @(posedge clock);
      cyc++;
      #1;
      if (!stall_s) begin
        if (idx < prog.size()) begin
          cur = prog[idx];
          idx++;
          if (is_md(cur)) sb.push_back(mk_exp(cur));
        end else begin
          cur = nop;
        end
        apply(cur);
      end
      if (active && cyc >= u_start + u_lat) begin
        bus.md_ready = 1'b1; bus.md_result = u_res; bus.md_exception = u_exc;
      end else begin
        bus.md_ready = (!active && cur.early && is_md(cur));
        bus.md_result = $urandom;
        bus.md_exception = 1'($urandom_range(0, 1));
      end
      if (idx >= prog.size() && sb.size() == 0 && !bus.busy) finished = 1;
    end
    if (!finished) begin
      n_cmp++; n_bad++;
      $display("FAIL stream_timeout: %0d ops still pending at cycle %0d", sb.size(), cyc);
    end

    // Reset mid-WAIT abandons the op; a late ready must not revive it.
    mon_en = 0;
    @(posedge clock); cyc++;
    #1 apply(mk(5'd0, 5'd6, 32'd3, 32'd5, 0, 0));
    bus.md_ready = 1'b0;
    @(negedge clock);
    check("rst_c0_stall", 64'(bus.stall), 64'h1);
    repeat (3) begin
      @(posedge clock); cyc++;
    end
    #2;
    check("rst_c3_busy", 64'(bus.busy), 64'h1);
    reset = 1'b0;
    apply(nop);
    #1 check_all_zero("rst_mid");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); cyc++;
    #1 bus.md_ready = 1'b1; bus.md_result = 32'hABCD; bus.md_exception = 1'b1;
    @(negedge clock);
    check("rst_late_ready_busy", 64'(bus.busy), 64'h0);
    check("rst_late_ready_stall", 64'(bus.stall), 64'h0);
    check("rst_late_ready_valid", 64'(bus.result_valid), 64'h0);
    @(posedge clock); cyc++;
    #1 bus.md_ready = 1'b0;
    @(negedge clock);
    check("rst_after_busy", 64'(bus.busy), 64'h0);
    check("rst_after_valid", 64'(bus.result_valid), 64'h0);
    check("rst_after_result", 64'(bus.result), 64'h0);
    check("rst_after_overflow", 64'(bus.result_overflow), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multdiv_stall_ctrl.md
# multdiv_stall_ctrl

Sequencing controller for the shared multi-cycle multiplier/divider unit in the 5-stage pipeline. It sits beside the X stage and watches the D/X opcode and ALU opcode. When an R-type `mult` or `div` reaches X, it:
- freezes PC, F/D and D/X;
- injects bubbles into X/M;
- launches and supervises the multdiv unit;
- delivers the result to X/M for exactly one cycle.

A watchdog forces completion with an exception if the unit never reports ready.

## Interface
Parameters:
- `MAX_WAIT`, default 40: maximum WAIT-state cycles before forced completion. Legal range 1..63.

Ports:
- `clock`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; low forces IDLE and clears all registers immediately.
- `op_x`  in  5  opcode held in D/X.
- `aluop_x`  in  5  ALU opcode field held in D/X.
- `rega_x`  in  32  operand A from D/X.
- `regb_x`  in  32  operand B from D/X.
- `md_ready`  in  1  multdiv unit result-ready flag.
- `md_result`  in  32  multdiv unit result.
- `md_exception`  in  1  multdiv unit overflow / divide-by-zero flag.
- `ctrl_mult`  out  1  one-cycle registered start pulse for a multiply.
- `ctrl_div`  out  1  one-cycle registered start pulse for a divide.
- `md_operand_a`  out  32  latched operand A for the unit.
- `md_operand_b`  out  32  latched operand B for the unit.
- `stall`  out  1  hold PC, PC_F, F/D and D/X write enables low.
- `xm_bubble`  out  1  X/M loads opcode 00000 with rd 0 instead of the X results.
- `result_valid`  out  1  X/M captures `result` in place of the ALU1 output.
- `result`  out  32  completed product or quotient.
- `result_overflow`  out  1  overflow flag to X/M alongside `result`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Decode: `md_op` = (`op_x` == 00000) & (`aluop_x` == 00110 for mult, or 00111 for div). All other encodings are ignored.
- States: IDLE, START, WAIT, DONE. Encoding is free; `busy` = state != IDLE.
- IDLE:
  - If `md_op`, latch `rega_x` and `regb_x` into `md_operand_a/b`, latch the kind (mult/div), and go to START.
  - Otherwise stay in IDLE.
- START:
  - Assert `ctrl_mult` or `ctrl_div` for this cycle only.
  - Clear the wait counter.
  - Go to WAIT.
  - `md_ready` is ignored in this state.
- WAIT:
  - If `md_ready`, capture `md_result` into `result` and `md_exception` into `result_overflow`, then go to DONE.
  - Otherwise, if the counter equals `MAX_WAIT`-1, set `result` = 0 and `result_overflow` = 1, then go to DONE.
  - Otherwise increment the counter and stay in WAIT.
- DONE:
  - `result_valid` = 1.
  - `stall` = 0, so D/X accepts the next instruction at the end of this cycle.
  - Go to IDLE unconditionally; a new `md_op` is only evaluated from IDLE.
- `stall` = `xm_bubble` = (IDLE & `md_op`) | START | WAIT. This is combinational so that the detecting cycle is already frozen.
- `result` and `result_overflow` hold their value until the next capture.
- `md_operand_a/b` hold until the next IDLE launch.
- Reset values: all outputs 0, counter 0, state IDLE.
- Reset mid-operation abandons the operation. A late `md_ready` after reset is ignored because the state is IDLE.

## Timing
- Cycle c0 is the first cycle `md_op` is seen in IDLE.
- c0: `stall` = 1.
- c1: START, with the start pulse.
- c2 onward: WAIT.
- If `md_ready` is sampled high in WAIT at cycle k, `result_valid` is high at cycle k+1.
- Minimum: ready at c2 gives `result_valid` at c3, so 3 stalled cycles.
- Watchdog: with no ready, WAIT occupies c2..c(MAX_WAIT+1) and DONE is at c(MAX_WAIT+2).
- Back-to-back mult/div: the second op enters X at DONE+1 and is detected in IDLE that cycle, so the earliest second start pulse is at DONE+2.
- Start pulses never overlap and never exceed one cycle per operation.

## Test plan
1. Mult 7×6, `md_ready` at c5:
   - `ctrl_mult` high only at c1.
   - `stall` and `xm_bubble` high c0–c5.
   - At c6: `result_valid` = 1, `result` = 42, `result_overflow` = 0.
2. Div 100/7, `md_ready` at c2:
   - `ctrl_div` high only at c1.
   - At c3: `result_valid` = 1, `result` = 14.
3. `md_ready` held high from c0:
   - Ready at c0/c1 is ignored.
   - Completion follows WAIT sampling at c2, so `result_valid` is at c3.
4. `MAX_WAIT` = 40, `md_ready` never asserted:
   - At c42: `result_valid` = 1, `result` = 0, `result_overflow` = 1.
   - `stall` is low at c42.
5. Mult then div back to back (ready one cycle after START each):
   - First `result_valid` at c3.
   - `ctrl_div` at c5.
   - Second `result_valid` at c7.
   - Confirm the non-md op `add` (aluop 00000) never asserts `stall`.
6. `reset` pulsed low in WAIT at c3:
   - All outputs 0 asynchronously.
   - `md_ready` at c4 has no effect.
   - After release, an idle non-md opcode leaves `busy` = 0.
